// File: rtl/pong_sound_fx.sv
// ---------------------------------------------------------------------------
// pong_sound_fx
//   Sound effect sequencer for a Pong game. A game event (score, paddle hit,
//   wall hit) starts a gated square-wave beep on the speaker pin:
//     - paddle : one 2 kHz beep of PADDLE_MS
//     - wall   : one 1 kHz beep of WALL_MS (2 kHz input divided by two)
//     - score  : 2 kHz beep SCORE_ON_MS, silence SCORE_GAP_MS, beep SCORE_ON_MS
//   Priority is score > paddle > wall. An event of equal or higher priority
//   than the sound in progress restarts it; a lower one is ignored.
//
// Ports
//   clk_100MHz    in  system clock, rising edge
//   rst_n         in  asynchronous active-low reset
//   i_tone_2000Hz in  2 kHz square wave, synchronous to clk_100MHz
//   i_hit_paddle  in  single-cycle pulse, ball hit a paddle
//   i_hit_wall    in  single-cycle pulse, ball hit top/bottom wall
//   i_score       in  single-cycle pulse, point scored
//   o_speaker     out registered, gated square wave
//   o_busy        out registered, high while a sound plays (including gap)
// ---------------------------------------------------------------------------
module pong_sound_fx #(
  parameter int unsigned TICKS_PER_MS = 100000,
  parameter int unsigned PADDLE_MS    = 50,
  parameter int unsigned WALL_MS      = 25,
  parameter int unsigned SCORE_ON_MS  = 100,
  parameter int unsigned SCORE_GAP_MS = 50
) (
  input  logic clk_100MHz,
  input  logic rst_n,
  input  logic i_tone_2000Hz,
  input  logic i_hit_paddle,
  input  logic i_hit_wall,
  input  logic i_score,
  output logic o_speaker,
  output logic o_busy
);

  // Counter load values: a state lasts exactly ms*TICKS_PER_MS cycles,
  // counting from load-1 down to 0 inclusive.
  localparam logic [31:0] C_PADDLE    = 32'(PADDLE_MS * TICKS_PER_MS) - 32'd1;
  localparam logic [31:0] C_WALL      = 32'(WALL_MS * TICKS_PER_MS) - 32'd1;
  localparam logic [31:0] C_SCORE_ON  = 32'(SCORE_ON_MS * TICKS_PER_MS) - 32'd1;
  localparam logic [31:0] C_SCORE_GAP = 32'(SCORE_GAP_MS * TICKS_PER_MS) - 32'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEEP1 = 2'd1,
    GAP   = 2'd2,
    BEEP2 = 2'd3
  } state_t;

  // Encoded so that a numerically larger value is a higher priority;
  // SND_NONE (idle) is below everything, so any event is accepted.
  typedef enum logic [1:0] {
    SND_NONE   = 2'd0,
    SND_WALL   = 2'd1,
    SND_PADDLE = 2'd2,
    SND_SCORE  = 2'd3
  } snd_t;

  state_t      r_state;
  snd_t        r_snd;
  logic [31:0] r_cnt;
  logic        r_div;
  logic        r_tone_d;
  logic        r_speaker;
  logic        r_busy;

  snd_t        w_evt;
  logic        w_accept;
  logic [31:0] w_load;
  logic        w_gate;
  logic        w_tone_sel;
  logic        w_tone_rise;

  // Highest-priority event present this cycle.
  always_comb begin
    w_evt = SND_NONE;
    if (i_score)           w_evt = SND_SCORE;
    else if (i_hit_paddle) w_evt = SND_PADDLE;
    else if (i_hit_wall)   w_evt = SND_WALL;
  end

  assign w_accept = (w_evt != SND_NONE) && (w_evt >= r_snd);

  always_comb begin
    case (w_evt)
      SND_SCORE:  w_load = C_SCORE_ON;
      SND_PADDLE: w_load = C_PADDLE;
      default:    w_load = C_WALL;
    endcase
  end

  // 1 kHz wall tone: toggle on each rising edge of the 2 kHz input. Free
  // running; events never reset it, so wall beeps start at arbitrary phase.
  assign w_tone_rise = i_tone_2000Hz & ~r_tone_d;

  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_tone_d <= 1'b0;
      r_div    <= 1'b0;
    end else begin
      r_tone_d <= i_tone_2000Hz;
      if (w_tone_rise) r_div <= ~r_div;
    end
  end

  assign w_gate     = (r_state == BEEP1) || (r_state == BEEP2);
  assign w_tone_sel = (r_snd == SND_WALL) ? r_div : i_tone_2000Hz;

  // Sequencer. r_busy is updated alongside r_state so that it always equals
  // (r_state != IDLE) without an extra cycle of lag.
  always_ff @(posedge clk_100MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_snd     <= SND_NONE;
      r_cnt     <= 32'd0;
      r_speaker <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_speaker <= w_gate & w_tone_sel;
      if (w_accept) begin
        r_state <= BEEP1;
        r_snd   <= w_evt;
        r_cnt   <= w_load;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          IDLE: begin
            r_cnt <= 32'd0;
          end
          BEEP1: begin
            if (r_cnt == 32'd0) begin
              if (r_snd == SND_SCORE) begin
                r_state <= GAP;
                r_cnt   <= C_SCORE_GAP;
              end else begin
                r_state <= IDLE;
                r_snd   <= SND_NONE;
                r_busy  <= 1'b0;
              end
            end else begin
              r_cnt <= r_cnt - 32'd1;
            end
          end
          GAP: begin
            if (r_cnt == 32'd0) begin
              r_state <= BEEP2;
              r_cnt   <= C_SCORE_ON;
            end else begin
              r_cnt <= r_cnt - 32'd1;
            end
          end
          BEEP2: begin
            if (r_cnt == 32'd0) begin
              r_state <= IDLE;
              r_snd   <= SND_NONE;
              r_busy  <= 1'b0;
            end else begin
              r_cnt <= r_cnt - 32'd1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_snd   <= SND_NONE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_speaker = r_speaker;
  assign o_busy    = r_busy;

endmodule

// File: doc/pong_sound_fx.md
PONG_SOUND_FX -- requirements
Module: pong_sound_fx

Interface
REQ-001 Parameter TICKS_PER_MS, default 100000, clock cycles per millisecond; must be >= 1.
REQ-002 Parameter PADDLE_MS, default 50, paddle beep length in ms.
REQ-003 Parameter WALL_MS, default 25, wall beep length in ms.
REQ-004 Parameters SCORE_ON_MS, default 100, and SCORE_GAP_MS, default 50: score beep and gap lengths in ms.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset; all ports are listed below.
REQ-006 Port clk_100MHz  in  1  system clock, rising edge.
REQ-007 Port rst_n  in  1  asynchronous, active-low reset.
REQ-008 Port i_tone_2000Hz  in  1  2 kHz square wave from the tone generator, synchronous to clk_100MHz.
REQ-009 Port i_hit_paddle  in  1  single-cycle pulse when the ball hits a paddle.
REQ-010 Port i_hit_wall  in  1  single-cycle pulse when the ball hits the top or bottom wall.
REQ-011 Port i_score  in  1  single-cycle pulse when a point is scored.
REQ-012 Port o_speaker  out  1  gated square wave to the speaker pin.
REQ-013 Port o_busy  out  1  high while any sound plays.

Function
REQ-014 The FSM SHALL have four states: IDLE, BEEP1, GAP, BEEP2.
REQ-015 Event priority SHALL be score > paddle > wall; simultaneous pulses act as the highest one only.
REQ-016 An event sampled at edge N SHALL load its state and duration counter at edge N; the new state is visible from cycle N+1.
- Score loads BEEP1 with SCORE_ON_MS.
- Paddle loads BEEP1 with PADDLE_MS.
- Wall loads BEEP1 with WALL_MS.
REQ-017 The duration counter SHALL be 32 bits, loaded with ms*TICKS_PER_MS-1, and decremented every cycle.
- A state lasts exactly ms*TICKS_PER_MS cycles.
- The counter SHALL not wrap.
REQ-018 Transitions at counter==0:
- BEEP1(score) -> GAP, loading SCORE_GAP_MS.
- GAP -> BEEP2, loading SCORE_ON_MS.
- BEEP2 -> IDLE.
- BEEP1(paddle or wall) -> IDLE.
REQ-019 During playback, an event of priority >= the current sound SHALL restart it from BEEP1 with a full duration; a lower-priority event SHALL be ignored.
REQ-020 Tone selection:
- Paddle and score use i_tone_2000Hz directly.
- Wall uses a 1 kHz wave: a divider register toggles on every rising edge of i_tone_2000Hz, detected with a one-cycle delayed copy.
REQ-021 The 1 kHz divider SHALL run continuously and is not reset by events.
REQ-022 The gate SHALL be high only in BEEP1 and BEEP2.
REQ-023 o_speaker SHALL be registered: o_speaker(t+1) = gate(t) AND selected_tone(t).
- It is 0 in IDLE and GAP.
- Latency from event pulse to first possible high output is 2 cycles.
REQ-024 o_busy SHALL be registered high whenever state != IDLE, including GAP.
REQ-025 A zero-length duration parameter is illegal; behaviour for it is unspecified.

Reset
REQ-026 On rst_n low, all registers SHALL clear immediately and asynchronously: state IDLE, counter 0, divider 0, tone delay 0, sound type none, o_speaker 0, o_busy 0.
REQ-027 Reset asserted mid-sound SHALL abort the sound; no output SHALL follow release until a new event arrives.
REQ-028 An event pulse coincident with the first clock edge after reset release SHALL be accepted normally.

Verification (TICKS_PER_MS=10, PADDLE_MS=5, WALL_MS=3, SCORE_ON_MS=4, SCORE_GAP_MS=2; tone period 20 cycles)
REQ-029 Paddle pulse at cycle 100 -> o_busy high for cycles 101..150 (50 cycles); o_speaker follows the 2 kHz tone delayed one cycle; o_speaker 0 after cycle 151.
REQ-030 Wall pulse -> o_busy high for 30 cycles; o_speaker period is 40 cycles (half frequency).
REQ-031 Score pulse -> 40 cycles tone, 20 cycles silent with o_busy still high, 40 cycles tone; 100 cycles busy total.
REQ-032 Simultaneous wall+paddle+score pulses -> score pattern only. Paddle pulse 10 cycles into a score sound -> ignored. Paddle pulse 20 cycles into a paddle sound -> busy extends to 50 cycles after the second pulse.
REQ-033 rst_n low for 3 cycles in the middle of a score GAP -> o_speaker and o_busy go 0 immediately and stay 0 after release with no further events.
